// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: grant IDs, FSM state encoding
// and default parameter values.
package sdram_arb_pkg;

   localparam int unsigned DEF_ADDR_W       = 24;
   localparam int unsigned DEF_DATA_W       = 16;
   localparam int unsigned DEF_MAX_PEND     = 8;
   localparam int unsigned DEF_STARVE_LIMIT = 16;

   // Grant ID, also the payload of the response tag FIFO
   typedef logic grant_t;
   localparam grant_t GNT_VIDEO = 1'b0;
   localparam grant_t GNT_CPU   = 1'b1;

   typedef logic [0:0] fsm_state_t;
   localparam fsm_state_t ST_IDLE = 1'b0;
   localparam fsm_state_t ST_HOLD = 1'b1;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Response tag FIFO: records which port issued each outstanding read.
// DEPTH must be a power of two, at least 2.
module sdram_arb_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_MAX_PEND
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  grant_t                 din,
   input  logic                   pop,
   output grant_t                 dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DEPTH-1:0] mem;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // A pop frees the slot being written when full, so push+pop is legal there
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port (video priority, CPU) Avalon-MM arbiter in front of one SDRAM slave.
// Optional CPU starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned MAX_PEND     = DEF_MAX_PEND,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   v_address,
   input  logic                v_read,
   output logic                v_waitrequest,
   output logic                v_readdatavalid,
   input  logic [ADDR_W-1:0]   c_address,
   input  logic                c_read,
   input  logic                c_write,
   input  logic [DATA_W-1:0]   c_writedata,
   input  logic [DATA_W/8-1:0] c_byteenable,
   output logic                c_waitrequest,
   output logic                c_readdatavalid,
   output logic [DATA_W-1:0]   readdata,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   input  logic                s_readdatavalid
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = $clog2(MAX_PEND) + 1;

   fsm_state_t        state;
   grant_t            h_grant;
   logic [ADDR_W-1:0] h_address;
   logic              h_read;
   logic              h_write;
   logic [DATA_W-1:0] h_writedata;
   logic [BE_W-1:0]   h_byteenable;

   grant_t            grant;
   logic [ADDR_W-1:0] cmd_address;
   logic              cmd_read;
   logic              cmd_write;
   logic [DATA_W-1:0] cmd_writedata;
   logic [BE_W-1:0]   cmd_byteenable;

   logic              fifo_full;
   logic              fifo_empty;
   grant_t            fifo_dout;
   logic [CNT_W-1:0]  unused_pend_count;

   logic v_elig;
   logic c_rd_elig;
   logic c_elig;
   logic starve_force;
   logic presenting;
   logic accept;
   logic push;
   logic pop;

   // Reads are only eligible while a tag slot is free; CPU writes never need one
   assign v_elig    = v_read & ~fifo_full;
   assign c_rd_elig = c_read & ~c_write & ~fifo_full;
   assign c_elig    = c_write | c_rd_elig;

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
   logic [SC_W-1:0] starve_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         starve_cnt <= '0;
      else if (~(c_read | c_write) || (accept && grant == GNT_CPU))
         starve_cnt <= '0;
      else if (accept && grant == GNT_VIDEO && starve_cnt != SC_W'(STARVE_LIMIT))
         starve_cnt <= starve_cnt + SC_W'(1);
   end

   assign starve_force = (starve_cnt == SC_W'(STARVE_LIMIT)) & c_elig;
`else
   logic unused_starve_limit;
   assign unused_starve_limit = (STARVE_LIMIT == 0);
   assign starve_force        = 1'b0;
`endif

   always_comb begin
      grant = h_grant;
      if (state == ST_IDLE)
         grant = (v_elig & ~starve_force) ? GNT_VIDEO : GNT_CPU;
   end

   // In HOLD the slave sees the captured command, not the live port inputs
   always_comb begin
      cmd_address    = h_address;
      cmd_read       = h_read;
      cmd_write      = h_write;
      cmd_writedata  = h_writedata;
      cmd_byteenable = h_byteenable;
      if (state == ST_IDLE) begin
         cmd_writedata = c_writedata;
         if (grant == GNT_VIDEO) begin
            cmd_address    = v_address;
            cmd_read       = v_elig;
            cmd_write      = 1'b0;
            cmd_byteenable = '1;
         end else begin
            cmd_address    = c_address;
            cmd_read       = c_rd_elig;
            cmd_write      = c_write;
            cmd_byteenable = c_byteenable;
         end
      end
      if (reset) begin
         cmd_read  = 1'b0;
         cmd_write = 1'b0;
      end
   end

   assign presenting = cmd_read | cmd_write;
   assign accept     = presenting & ~s_waitrequest;
   assign push       = accept & cmd_read;
   assign pop        = s_readdatavalid & ~fifo_empty & ~reset;

   assign s_address    = cmd_address;
   assign s_read       = cmd_read;
   assign s_write      = cmd_write;
   assign s_writedata  = cmd_writedata;
   assign s_byteenable = cmd_byteenable;

   assign v_waitrequest = ~(presenting & (grant == GNT_VIDEO)) | s_waitrequest;
   assign c_waitrequest = ~(presenting & (grant == GNT_CPU)) | s_waitrequest;

   assign readdata        = s_readdata;
   assign v_readdatavalid = pop & (fifo_dout == GNT_VIDEO);
   assign c_readdatavalid = pop & (fifo_dout == GNT_CPU);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         h_grant      <= GNT_VIDEO;
         h_address    <= '0;
         h_read       <= 1'b0;
         h_write      <= 1'b0;
         h_writedata  <= '0;
         h_byteenable <= '0;
      end else if (state == ST_IDLE) begin
         if (presenting & s_waitrequest) begin
            state        <= ST_HOLD;
            h_grant      <= grant;
            h_address    <= cmd_address;
            h_read       <= cmd_read;
            h_write      <= cmd_write;
            h_writedata  <= cmd_writedata;
            h_byteenable <= cmd_byteenable;
         end
      end else if (~s_waitrequest) begin
         state <= ST_IDLE;
      end
   end

   sdram_arb_tag_fifo #(
      .DEPTH (MAX_PEND)
   ) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (grant),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (unused_pend_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected slave commands and port
// responses are queued by the stimulus and checked by a negedge monitor.
module tb_sdram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] v_address;
   logic        v_read;
   logic        v_waitrequest;
   logic        v_readdatavalid;
   logic [23:0] c_address;
   logic        c_read;
   logic        c_write;
   logic [15:0] c_writedata;
   logic [1:0]  c_byteenable;
   logic        c_waitrequest;
   logic        c_readdatavalid;
   logic [15:0] readdata;
   logic [23:0] s_address;
   logic        s_read;
   logic        s_write;
   logic [15:0] s_writedata;
   logic [1:0]  s_byteenable;
   logic        s_waitrequest;
   logic [15:0] s_readdata;
   logic        s_readdatavalid;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [23:0] addr;
      logic [15:0] wd;
      logic [1:0]  be;
   } cmd_t;

   typedef struct {
      logic        port;   // 0 = video, 1 = CPU
      logic [15:0] data;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cpu_slot;
   int vcnt;
   logic cur_port;
   logic prev_port;

   always #5 clk = ~clk;

   sdram_port_arbiter #(
      .ADDR_W       (24),
      .DATA_W       (16),
      .MAX_PEND     (8),
      .STARVE_LIMIT (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .v_address       (v_address),
      .v_read          (v_read),
      .v_waitrequest   (v_waitrequest),
      .v_readdatavalid (v_readdatavalid),
      .c_address       (c_address),
      .c_read          (c_read),
      .c_write         (c_write),
      .c_writedata     (c_writedata),
      .c_byteenable    (c_byteenable),
      .c_waitrequest   (c_waitrequest),
      .c_readdatavalid (c_readdatavalid),
      .readdata        (readdata),
      .s_address       (s_address),
      .s_read          (s_read),
      .s_write         (s_write),
      .s_writedata     (s_writedata),
      .s_byteenable    (s_byteenable),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_rd(input logic [23:0] addr, input logic [1:0] be);
      cmd_t c;
      c.rd = 1'b1; c.wr = 1'b0; c.addr = addr; c.wd = '0; c.be = be;
      cmd_q.push_back(c);
   endtask

   task automatic exp_wr(input logic [23:0] addr, input logic [15:0] wd, input logic [1:0] be);
      cmd_t c;
      c.rd = 1'b0; c.wr = 1'b1; c.addr = addr; c.wd = wd; c.be = be;
      cmd_q.push_back(c);
   endtask

   task automatic exp_rsp(input logic port, input logic [15:0] data);
      rsp_t r;
      r.port = port; r.data = data;
      rsp_q.push_back(r);
   endtask

   task automatic respond(input logic [15:0] data, input logic port);
      s_readdatavalid = 1'b1;
      s_readdata      = data;
      exp_rsp(port, data);
      tick();
      s_readdatavalid = 1'b0;
   endtask

   // Monitor: every accepted slave command and every port strobe pops the scoreboard
   always @(negedge clk) begin
      cmd_t ec;
      rsp_t er;
      if ((s_read | s_write) && !s_waitrequest) begin
         if (cmd_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_unexpected: got rd=%0b wr=%0b addr=%0h, expected no command", s_read, s_write, s_address);
         end else begin
            ec = cmd_q.pop_front();
            chk("cmd_kind", {s_read, s_write}, {ec.rd, ec.wr});
            chk("cmd_addr", s_address, ec.addr);
            chk("cmd_be", s_byteenable, ec.be);
            if (ec.wr) chk("cmd_wdata", s_writedata, ec.wd);
         end
      end
      if (v_readdatavalid || c_readdatavalid) begin
         if (rsp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_unexpected: got v=%0b c=%0b data=%0h, expected no strobe", v_readdatavalid, c_readdatavalid, readdata);
         end else begin
            er = rsp_q.pop_front();
            chk("rsp_port", {v_readdatavalid, c_readdatavalid}, er.port ? 2'b01 : 2'b10);
            chk("rsp_data", readdata, er.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      v_address = '0; c_address = '0; c_writedata = '0; c_byteenable = 2'b11;
      c_read = 1'b0; s_waitrequest = 1'b0; s_readdata = '0;
      v_read = 1'b1; c_write = 1'b1; s_readdatavalid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s_read",  s_read, 0);
      chk("rst_s_write", s_write, 0);
      chk("rst_v_wait",  v_waitrequest, 1);
      chk("rst_c_wait",  c_waitrequest, 1);
      chk("rst_v_rdv",   v_readdatavalid, 0);
      chk("rst_c_rdv",   c_readdatavalid, 0);
      tick();
      v_read = 1'b0; c_write = 1'b0; s_readdatavalid = 1'b0;
      reset = 1'b0;
      tick();

      // video read and CPU write together: video first, write next cycle
      v_read = 1'b1; v_address = 24'h000010;
      c_write = 1'b1; c_address = 24'h000020; c_writedata = 16'h1234;
      exp_rd(24'h000010, 2'b11);
      exp_wr(24'h000020, 16'h1234, 2'b11);
      @(negedge clk);
      chk("s1_v_wait", v_waitrequest, 0);
      chk("s1_c_wait", c_waitrequest, 1);
      tick();
      v_read = 1'b0;
      @(negedge clk);
      chk("s1_c_wait_next", c_waitrequest, 0);
      tick();
      c_write = 1'b0;
      respond(16'h5555, 1'b0);

      // slave stall: command held for 4 cycles, CPU kept waiting
      v_read = 1'b1; v_address = 24'h000100;
      c_read = 1'b1; c_address = 24'h000300; c_byteenable = 2'b01;
      s_waitrequest = 1'b1;
      exp_rd(24'h000100, 2'b11);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) s_waitrequest = 1'b0;
         @(negedge clk);
         chk("s2_addr",   s_address, 24'h000100);
         chk("s2_read",   s_read, 1);
         chk("s2_c_wait", c_waitrequest, 1);
         chk("s2_v_wait", v_waitrequest, (i == 3) ? 1'b0 : 1'b1);
         tick();
      end
      v_read = 1'b0;
      exp_rd(24'h000300, 2'b01);
      @(negedge clk);
      chk("s2_c_wait_go", c_waitrequest, 0);
      tick();
      c_read = 1'b0; c_byteenable = 2'b11;
      respond(16'h1111, 1'b0);
      respond(16'h2222, 1'b1);

      // fill the tag FIFO; writes still pass, reads wait for a pop
      v_read = 1'b1;
      for (int i = 0; i < 8; i++) begin
         v_address = 24'(24'h000400 + i);
         exp_rd(24'(24'h000400 + i), 2'b11);
         tick();
      end
      v_address = 24'h000408;
      c_write = 1'b1; c_address = 24'h000500; c_writedata = 16'hBEEF;
      exp_wr(24'h000500, 16'hBEEF, 2'b11);
      @(negedge clk);
      chk("s3_v_wait_full", v_waitrequest, 1);
      chk("s3_c_wait_wr",   c_waitrequest, 0);
      tick();
      c_write = 1'b0;
      @(negedge clk);
      chk("s3_read_blocked", s_read, 0);
      tick();
      s_readdatavalid = 1'b1; s_readdata = 16'h7000;
      exp_rsp(1'b0, 16'h7000);
      exp_rd(24'h000408, 2'b11);
      @(negedge clk);
      chk("s3_v_rdv",      v_readdatavalid, 1);
      chk("s3_v_wait_pop", v_waitrequest, 1);
      tick();
      s_readdatavalid = 1'b0;
      @(negedge clk);
      chk("s3_v_wait_9th", v_waitrequest, 0);
      tick();
      v_read = 1'b0;
      for (int i = 0; i < 8; i++) respond(16'(16'h7001 + i), 1'b0);

      // interleaved V, C, V reads
      v_read = 1'b1; v_address = 24'h000600;
      c_read = 1'b1; c_address = 24'h000700;
      exp_rd(24'h000600, 2'b11);
      @(negedge clk);
      chk("s4_c_wait", c_waitrequest, 1);
      tick();
      v_read = 1'b0;
      exp_rd(24'h000700, 2'b11);
      tick();
      c_read = 1'b0; v_read = 1'b1; v_address = 24'h000601;
      exp_rd(24'h000601, 2'b11);
      tick();
      v_read = 1'b0;
      respond(16'hAAAA, 1'b0);
      respond(16'hBBBB, 1'b1);
      respond(16'hCCCC, 1'b0);

      // continuous video traffic with a CPU read pending
`ifdef ARB_STARVE_GUARD_EN
      cpu_slot = 16;
`else
      cpu_slot = -1;
`endif
      vcnt = 0;
      prev_port = 1'b0;
      v_read = 1'b1; c_address = 24'h000900;
      for (int i = 0; i < 20; i++) begin
         cur_port  = (i == cpu_slot);
         c_read    = (cpu_slot < 0) || (i <= cpu_slot);
         v_address = 24'(24'h000800 + vcnt);
         if (cur_port) exp_rd(24'h000900, 2'b11);
         else          exp_rd(24'(24'h000800 + vcnt), 2'b11);
         if (i > 0) begin
            s_readdatavalid = 1'b1;
            s_readdata      = 16'(16'hD000 + i);
            exp_rsp(prev_port, 16'(16'hD000 + i));
         end
         @(negedge clk);
         chk("s5_c_wait", c_waitrequest, !cur_port);
         tick();
         if (!cur_port) vcnt++;
         prev_port = cur_port;
      end
      v_read = 1'b0; c_read = 1'b0;
      respond(16'hD014, prev_port);

      // reset with reads outstanding: later responses are dropped
      v_read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v_address = 24'(24'h000A00 + i);
         exp_rd(24'(24'h000A00 + i), 2'b11);
         tick();
      end
      reset = 1'b1;
      @(negedge clk);
      chk("s6_rst_v_wait", v_waitrequest, 1);
      chk("s6_rst_s_read", s_read, 0);
      tick();
      v_read = 1'b0;
      reset  = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         s_readdatavalid = 1'b1;
         s_readdata      = 16'(16'hEEE0 + i);
         @(negedge clk);
         chk("s6_no_v_rdv", v_readdatavalid, 0);
         chk("s6_no_c_rdv", c_readdatavalid, 0);
         tick();
         s_readdatavalid = 1'b0;
         tick();
      end

      repeat (2) tick();
      chk("cmd_q_drained", cmd_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, word address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 16, data width of all ports.
REQ-003 SHALL have parameter MAX_PEND, default 8 (power of 2), maximum number of outstanding reads.
REQ-004 SHALL have parameter STARVE_LIMIT, default 16, number of consecutive video grants before the CPU is forced in.
REQ-005 SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous reset, active-high.
REQ-006 SHALL have the following ports:
- v_address  in  ADDR_W  video port read address.
- v_read  in  1  video read request.
- v_waitrequest  out  1  video command stall.
- v_readdatavalid  out  1  readdata belongs to the video port.
- c_address  in  ADDR_W  CPU port address.
- c_read  in  1  CPU read request.
- c_write  in  1  CPU write request.
- c_writedata  in  DATA_W  CPU write data.
- c_byteenable  in  DATA_W/8  CPU byte enables.
- c_waitrequest  out  1  CPU command stall.
- c_readdatavalid  out  1  readdata belongs to the CPU port.
- readdata  out  DATA_W  shared read data, equal to s_readdata.
- s_address  out  ADDR_W  address to the SDRAM controller slave.
- s_read  out  1  read command to the slave.
- s_write  out  1  write command to the slave.
- s_writedata  out  DATA_W  write data to the slave.
- s_byteenable  out  DATA_W/8  byte enables to the slave; all ones for video reads.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_W  slave read data.
- s_readdatavalid  in  1  slave read response strobe.

Function
REQ-007 SHALL follow Avalon-MM pipelined-read rules: a command is accepted in a cycle where (s_read|s_write)=1 and s_waitrequest=0.
REQ-008 SHALL use a two-state FSM:
- IDLE: the grant is chosen combinationally from the current requests.
- HOLD: entered when a command is presented and s_waitrequest=1; the grant is frozen and the slave outputs are held stable until acceptance, then the FSM returns to IDLE.
REQ-009 SHALL give the video port priority over the CPU; the CPU is granted only when v_read=0, or when the starvation override is active (REQ-015).
REQ-010 SHALL hold waitrequest=1 on the non-granted port; the granted port's waitrequest SHALL equal s_waitrequest. The arbiter adds zero cycles of command latency.
REQ-011 SHALL push the grant ID (0=video, 1=CPU) into a MAX_PEND-deep tag FIFO on every accepted read.
REQ-012 SHALL pop the tag FIFO on every s_readdatavalid and assert v_readdatavalid or c_readdatavalid in that same cycle, as the popped tag selects; the response path adds zero latency.
REQ-013 SHALL block reads while the FIFO holds MAX_PEND entries: both read requesters see waitrequest=1, while CPU writes still proceed.
REQ-014 SHALL handle FIFO boundary cases as follows:
- A push and a pop in the same cycle leave the count unchanged; a pop in the full state is allowed.
- s_readdatavalid with the FIFO empty is discarded: no port strobe, no pop.

Reset
REQ-016 SHALL, while reset=1, clear the FIFO, the starvation counter and the FSM (to IDLE), and drive s_read=s_write=0, v_waitrequest=c_waitrequest=1, v_readdatavalid=c_readdatavalid=0.
REQ-017 SHALL, after a reset that occurs mid-operation, discard responses for reads issued before the reset (FIFO empty, per REQ-014).

Configuration
REQ-015 SHALL implement the starvation guard only when ARB_STARVE_GUARD_EN is defined:
- With the macro: a counter increments on each accepted video command while c_read|c_write=1, and clears on CPU acceptance or when the CPU is idle. At count=STARVE_LIMIT the CPU wins the next IDLE arbitration.
- Without the macro: strict video priority, and no counter logic is present.

Structure
REQ-018 SHALL place the grant-ID encoding, the FSM state typedef and the default parameter constants in package sdram_arb_pkg.
REQ-019 SHALL implement the tag FIFO as sub-module sdram_arb_tag_fifo (1-bit wide, MAX_PEND deep, with count, full and empty outputs).

Verification
REQ-020 SHALL cover, as directed bench scenarios:
- v_read and c_write asserted together, s_waitrequest=0 -> video granted first, CPU write accepted in the next cycle.
- Video read at 0x000100 with s_waitrequest=1 for 3 cycles, CPU requesting -> s_address held at 0x000100 for all 4 cycles, c_waitrequest=1 throughout.
- 8 video reads issued and unanswered, then a 9th read plus a CPU write -> read stalled, write accepted; one s_readdatavalid -> v_readdatavalid=1 and the 9th read accepted in the next cycle.
- Interleaved reads V,C,V, responses 0xAAAA,0xBBBB,0xCCCC -> strobes v,c,v with readdata in that order.
- ARB_STARVE_GUARD_EN defined, v_read held high, CPU read pending -> CPU granted exactly after 16 video acceptances; without the macro -> CPU never granted.
- Reset with 3 reads outstanding, then 3 s_readdatavalid pulses -> no port strobe.
